// File: rtl/attopu_pkg.sv
// Shared types and constants for the attopu fetch/PC stage.
package attopu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [1:0] PCSEL_INC     = 2'b00;
  localparam logic [1:0] PCSEL_REL     = 2'b01;
  localparam int         PCSEL_REG_BIT = 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/attopu_fetch_if.sv
// Instruction-memory req/ack bus between the fetch stage and instruction memory.
interface attopu_fetch_if
  import attopu_pkg::*;
#(
  parameter int ADDR_W = 16
);

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/attopu_pc_next.sv
// Combinational next-PC selection: increment, relative branch or register target.
module attopu_pc_next
  import attopu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        nextPCSel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] regPCValue,
  output logic [ADDR_W-1:0] next_pc
);

  // Only the high select bit is trusted for the register path; bit 0 may be x.
  always_comb begin
    next_pc = pc + ADDR_W'(1);
    if (nextPCSel[PCSEL_REG_BIT]) begin
      next_pc = regPCValue;
    end else if (nextPCSel == PCSEL_REL) begin
      next_pc = pc + addr;
    end
  end

endmodule

// File: rtl/attopu_fetch.sv
// Fetch/PC stage: BOOT -> FETCH (req/ack) -> EXEC (one decoder cycle) -> FETCH ...
module attopu_fetch
  import attopu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  attopu_fetch_if.master      imem,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  input  logic [1:0]          nextPCSel,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [ADDR_W-1:0]   regPCValue,
  input  logic                exec_stall,
  output logic [ADDR_W-1:0]   pc,
  output logic [15:0]         retire_count
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [15:0]        retire_q, retire_d;
  logic [ADDR_W-1:0]  next_pc;

  attopu_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc         (pc_q),
    .nextPCSel  (nextPCSel),
    .addr       (addr),
    .regPCValue (regPCValue),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    retire_d = retire_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem.ack) begin
          instr_d = imem.rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Decoder outputs are consumed only on the cycle that leaves EXEC.
        if (!exec_stall) begin
          pc_d     = next_pc;
          retire_d = retire_q + 16'd1;
          state_d  = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      retire_q <= retire_d;
    end
  end

  assign imem.req     = (state_q == FETCH);
  assign imem.addr    = pc_q;
  assign instr_valid  = (state_q == EXEC);
  assign instruction  = instr_q;
  assign pc           = pc_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_attopu_fetch.sv
// Directed self-checking bench for attopu_fetch with hand-computed expectations.
module tb_attopu_fetch;
  import attopu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [1:0]  nextPCSel;
  logic [15:0] addr;
  logic [15:0] regPCValue;
  logic        exec_stall;
  logic [15:0] pc;
  logic [15:0] retire_count;

  int checks = 0;
  int errors = 0;

  attopu_fetch_if #(.ADDR_W(16)) imem_bus ();

  attopu_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (imem_bus.master),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .nextPCSel    (nextPCSel),
    .addr         (addr),
    .regPCValue   (regPCValue),
    .exec_stall   (exec_stall),
    .pc           (pc),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-wait fetch of one word at exp_addr, then execute it with the given PC select.
  task automatic do_instr(input logic [15:0] word, input logic [15:0] exp_addr,
                          input logic [1:0] sel, input logic [15:0] a,
                          input logic [15:0] regv, input logic [15:0] exp_pc,
                          input logic [15:0] exp_ret);
    check("fetch_req", 32'(imem_bus.req), 32'd1);
    check("fetch_addr", 32'(imem_bus.addr), 32'(exp_addr));
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = word;
    tick();
    imem_bus.ack = 1'b0;
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_req", 32'(imem_bus.req), 32'd0);
    check("exec_instr", 32'(instruction), 32'(word));
    nextPCSel  = sel;
    addr       = a;
    regPCValue = regv;
    tick();
    nextPCSel  = 2'b00;
    addr       = 16'h0000;
    regPCValue = 16'h0000;
    check("next_pc", 32'(pc), 32'(exp_pc));
    check("retire", 32'(retire_count), 32'(exp_ret));
    check("post_valid", 32'(instr_valid), 32'd0);
    $display("instr %h @%h sel=%b -> pc=%h retired=%0d", word, exp_addr, sel, pc, retire_count);
  endtask

  initial begin
    reset          = 1'b1;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 16'h7777;
    nextPCSel      = 2'b00;
    addr           = 16'h0000;
    regPCValue     = 16'h0000;
    exec_stall     = 1'b0;
    tick();
    tick();
    // Reset state (ack during reset must be ignored)
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_req", 32'(imem_bus.req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_retire", 32'(retire_count), 32'd0);
    reset        = 1'b0;
    imem_bus.ack = 1'b0;
    check("boot_req", 32'(imem_bus.req), 32'd0);
    tick();

    // 1: zero-wait sequential fetches
    for (int i = 0; i < 4; i++)
      do_instr(16'h1000 + 16'(i), 16'(i), 2'b00, 16'h0, 16'h0, 16'(i + 1), 16'(i + 1));

    // 2: delayed ack at pc=5
    do_instr(16'h1004, 16'h0004, 2'b00, 16'h0, 16'h0, 16'h0005, 16'd5);
    for (int i = 0; i < 3; i++) begin
      check("wait_req", 32'(imem_bus.req), 32'd1);
      check("wait_addr", 32'(imem_bus.addr), 32'h5);
      check("wait_instr", 32'(instruction), 32'h1004);
      check("wait_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    do_instr(16'h2222, 16'h0005, 2'b01, 16'h000B, 16'h0, 16'h0010, 16'd6);

    // 3: relative branches, backwards and to self
    do_instr(16'h3000, 16'h0010, 2'b01, 16'hFFFC, 16'h0, 16'h000C, 16'd7);
    do_instr(16'h3001, 16'h000C, 2'b01, 16'h0004, 16'h0, 16'h0010, 16'd8);
    do_instr(16'h3002, 16'h0010, 2'b01, 16'h0000, 16'h0, 16'h0010, 16'd9);

    // 4: register targets (bit 0 don't-care) and PC wrap
    do_instr(16'h4000, 16'h0010, 2'b10, 16'h0000, 16'h0003, 16'h0003, 16'd10);
    do_instr(16'h4001, 16'h0003, 2'b1x, 16'h0000, 16'hABCD, 16'hABCD, 16'd11);
    do_instr(16'h4002, 16'hABCD, 2'b11, 16'h1234, 16'hFFFF, 16'hFFFF, 16'd12);
    do_instr(16'h4003, 16'hFFFF, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'd13);

    // 5: four stall cycles in EXEC; decoder inputs and acks ignored meanwhile
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 16'h5555;
    tick();
    check("stall_enter", 32'(instr_valid), 32'd1);
    exec_stall     = 1'b1;
    nextPCSel      = 2'b01;
    addr           = 16'h0055;
    imem_bus.rdata = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", 32'(pc), 32'h0);
      check("stall_retire", 32'(retire_count), 32'd13);
      check("stall_instr", 32'(instruction), 32'h5555);
    end
    exec_stall   = 1'b0;
    imem_bus.ack = 1'b0;
    nextPCSel    = 2'b00;
    addr         = 16'h0000;
    tick();
    check("release_pc", 32'(pc), 32'h1);
    check("release_retire", 32'(retire_count), 32'd14);
    check("release_valid", 32'(instr_valid), 32'd0);
    $display("stall released -> pc=%h retired=%0d", pc, retire_count);

    // 6: reset mid-FETCH, then a late ack while in BOOT
    tick();
    check("midfetch_req", 32'(imem_bus.req), 32'd1);
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 16'hBEEF;
    check("r6_pc", 32'(pc), 32'h0);
    check("r6_instr", 32'(instruction), 32'h0);
    check("r6_valid", 32'(instr_valid), 32'd0);
    check("r6_req", 32'(imem_bus.req), 32'd0);
    check("r6_retire", 32'(retire_count), 32'd0);
    tick();
    imem_bus.ack = 1'b0;
    check("late_ack_instr", 32'(instruction), 32'h0);
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    do_instr(16'h1234, 16'h0000, 2'b00, 16'h0, 16'h0, 16'h0001, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
